spi8_mem_arbiter: RTL and testbench

- Transaction sequencer and two-port arbiter for the octal-SPI DDR memory attached to the spi8ddr pad block.
- Runs in the 192 MHz spi8 clock domain; one 16-bit DDR word per clk.
- Builds command, address, dummy and data phases; drives spi_ncs and the pad output enable.
- Shares the memory between requester 0 (ADC sample logger, writes) and requester 1 (readout/display, reads) with round-robin grant.

---
 rtl/spi8_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_spi8_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi8_mem_arbiter.sv
// rtl/spi8_mem_arbiter.sv - octal-SPI DDR transaction sequencer with two-port round-robin grant
module spi8_mem_arbiter #(
   parameter logic [15:0] CMD_RD = 16'hEE11,
   parameter logic [15:0] CMD_WR = 16'h12ED,
   parameter int          DUMMY  = 8,
   parameter int          CS_GAP = 3,
   parameter int          RD_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_req0_valid,
   input  logic        i_req0_write,
   input  logic [31:0] i_req0_addr,
   input  logic [7:0]  i_req0_len,
   output logic        o_req0_ready,
   input  logic [15:0] i_req0_wdata,
   output logic        o_req0_wack,
   input  logic        i_req1_valid,
   input  logic        i_req1_write,
   input  logic [31:0] i_req1_addr,
   input  logic [7:0]  i_req1_len,
   output logic        o_req1_ready,
   input  logic [15:0] i_req1_wdata,
   output logic        o_req1_wack,
   output logic [15:0] o_rdata,
   output logic        o_req0_rvalid,
   output logic        o_req1_rvalid,
   output logic        o_busy,
   output logic        o_spi_ncs,
   output logic        o_spi_oe,
   output logic [15:0] o_spi_dout,
   input  logic [15:0] i_spi_din
);
   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_DUMMY, S_DATA, S_GAP
   } state_t;

   state_t            r_state, w_next;
   logic              r_gnt;       // requester owning the current/last transaction
   logic              r_write;
   logic [31:0]       r_addr;
   logic [8:0]        r_count;
   logic [4:0]        r_wait;
   logic [RD_LAT-1:0] r_pipe_v;
   logic [RD_LAT-1:0] r_pipe_tag;
   logic [15:0]       r_rdata;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic              w_grant;
   logic              w_sel;
   logic              w_rd_beat;

   // with both requesting, the requester not served last wins
   assign w_grant      = (r_state == S_IDLE) && i_reset_n && (i_req0_valid || i_req1_valid);
   assign w_sel        = (i_req0_valid && i_req1_valid) ? ~r_gnt : i_req1_valid;
   assign o_req0_ready = w_grant && !w_sel;
   assign o_req1_ready = w_grant && w_sel;
   assign w_rd_beat    = (r_state == S_DATA) && !r_write;
   assign o_busy       = (r_state != S_IDLE);
   assign o_rdata       = r_rdata;
   assign o_req0_rvalid = r_rvalid0;
   assign o_req1_rvalid = r_rvalid1;

   always_comb begin
      w_next      = r_state;
      o_spi_ncs   = 1'b1;
      o_spi_oe    = 1'b0;
      o_spi_dout  = 16'h0000;
      o_req0_wack = 1'b0;
      o_req1_wack = 1'b0;
      case (r_state)
         S_IDLE: if (w_grant) w_next = S_CMD;
         S_CMD: begin
            w_next     = S_ADDR_HI;
            o_spi_ncs  = 1'b0;
            o_spi_oe   = 1'b1;
            o_spi_dout = r_write ? CMD_WR : CMD_RD;
         end
         S_ADDR_HI: begin
            w_next     = S_ADDR_LO;
            o_spi_ncs  = 1'b0;
            o_spi_oe   = 1'b1;
            o_spi_dout = r_addr[31:16];
         end
         S_ADDR_LO: begin
            w_next     = r_write ? S_DATA : S_DUMMY;
            o_spi_ncs  = 1'b0;
            o_spi_oe   = 1'b1;
            o_spi_dout = r_addr[15:0];
         end
         S_DUMMY: begin
            if (r_wait == 5'd0) w_next = S_DATA;
            o_spi_ncs = 1'b0;
         end
         S_DATA: begin
            if (r_count == 9'd1) w_next = S_GAP;
            o_spi_ncs = 1'b0;
            if (r_write) begin
               o_spi_oe    = 1'b1;
               o_spi_dout  = r_gnt ? i_req1_wdata : i_req0_wdata;
               o_req0_wack = !r_gnt;
               o_req1_wack = r_gnt;
            end
         end
         S_GAP: if (r_wait == 5'd0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_gnt      <= 1'b1;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_count    <= '0;
         r_wait     <= '0;
         r_pipe_v   <= '0;
         r_pipe_tag <= '0;
         r_rdata    <= '0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_gnt   <= w_sel;
            r_write <= w_sel ? i_req1_write : i_req0_write;
            r_addr  <= w_sel ? i_req1_addr : i_req0_addr;
            // len 0 loads 256 through the ninth bit
            r_count <= w_sel ? {i_req1_len == 8'd0, i_req1_len} : {i_req0_len == 8'd0, i_req0_len};
         end
         case (r_state)
            S_ADDR_LO:      r_wait <= 5'(DUMMY - 1);
            S_DUMMY, S_GAP: r_wait <= r_wait - 5'd1;
            S_DATA: begin
               r_count <= r_count - 9'd1;
               r_wait  <= 5'(CS_GAP - 1);
            end
            default: ;
         endcase
         r_pipe_v[0]   <= w_rd_beat;
         r_pipe_tag[0] <= r_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            r_pipe_v[i]   <= r_pipe_v[i-1];
            r_pipe_tag[i] <= r_pipe_tag[i-1];
         end
         r_rdata   <= i_spi_din;
         r_rvalid0 <= r_pipe_v[RD_LAT-1] && !r_pipe_tag[RD_LAT-1];
         r_rvalid1 <= r_pipe_v[RD_LAT-1] && r_pipe_tag[RD_LAT-1];
      end
   end
endmodule

// File: tb/tb_spi8_mem_arbiter.sv
// tb/tb_spi8_mem_arbiter.sv - self-checking bench for spi8_mem_arbiter
module tb_spi8_mem_arbiter;
   localparam logic [15:0] CMD_RD = 16'hEE11;
   localparam logic [15:0] CMD_WR = 16'h12ED;
   localparam int DUMMY  = 8;
   localparam int CS_GAP = 3;
   localparam int RD_LAT = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [1:0]       v, wr, rdy, wack, rv;
   logic [1:0][31:0] addr;
   logic [1:0][7:0]  len;
   logic [1:0][15:0] wdata;
   logic [15:0]      rdata, dout, din;
   logic             busy, ncs, oe;

   logic [15:0] dat [256];
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int          n;
      bit          w;
      logic [31:0] a;
      logic [7:0]  l;
      int          pat;
      logic [15:0] base;
      int          e_ncs;
      int          e_busy;
      int          e_words;
      int          e_first;
   } vec_t;
   vec_t tbl [6];

   always #5 clk = ~clk;

   spi8_mem_arbiter #(
      .CMD_RD(CMD_RD), .CMD_WR(CMD_WR), .DUMMY(DUMMY), .CS_GAP(CS_GAP), .RD_LAT(RD_LAT)
   ) dut (
      .i_clk(clk), .i_reset_n(reset_n),
      .i_req0_valid(v[0]), .i_req0_write(wr[0]), .i_req0_addr(addr[0]), .i_req0_len(len[0]),
      .o_req0_ready(rdy[0]), .i_req0_wdata(wdata[0]), .o_req0_wack(wack[0]),
      .i_req1_valid(v[1]), .i_req1_write(wr[1]), .i_req1_addr(addr[1]), .i_req1_len(len[1]),
      .o_req1_ready(rdy[1]), .i_req1_wdata(wdata[1]), .o_req1_wack(wack[1]),
      .o_rdata(rdata), .o_req0_rvalid(rv[0]), .o_req1_rvalid(rv[1]), .o_busy(busy),
      .o_spi_ncs(ncs), .o_spi_oe(oe), .o_spi_dout(dout), .i_spi_din(din)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      v = '0; wr = '0; addr = '0; len = '0; wdata = '0; din = '0;
      repeat (3) tick();
      reset_n = 1'b1;
   endtask

   task automatic fill(input int pat, input logic [15:0] base);
      for (int i = 0; i < 256; i++) begin
         case (pat)
            0:       dat[i] = base + 16'(i);
            1:       dat[i] = (i % 2 == 0) ? base : ~base;
            default: dat[i] = 16'($urandom);
         endcase
      end
   endtask

   // Reference: a transaction is CMD, ADDR_HI, ADDR_LO, [DUMMY x DUMMY], len data clks, CS_GAP idle clks;
   // read word i returns on spi_din RD_LAT clks after its data clk and is reported one clk later.
   task automatic run_txn(input int id, input int n, input bit w, input logic [31:0] a, input logic [7:0] l,
                          output int o_ncs, output int o_busy, output int o_words, output int o_first);
      int L, ds, total;
      bit in_data, exp_rv;
      logic [15:0] exp_dout;
      logic [22:0] act, exp;
      L     = (l == 8'd0) ? 256 : int'(l);
      ds    = w ? 3 : 3 + DUMMY;
      total = ds + L + CS_GAP;
      o_ncs = 0; o_busy = 0; o_words = 0; o_first = -1;
      tick();
      v[n] = 1'b1; wr[n] = w; addr[n] = a; len[n] = l;
      @(negedge clk);
      chk($sformatf("t%0d grant", id), 64'(rdy), (n == 0) ? 64'd1 : 64'd2);
      tick();
      v[n] = 1'b0;
      for (int k = 0; k < total + RD_LAT + 1; k++) begin
         if (k > 0) tick();
         in_data  = (k >= ds) && (k < ds + L);
         wdata[0] = 16'($urandom);
         wdata[1] = 16'($urandom);
         if (w && in_data) wdata[n] = dat[k - ds];
         din = 16'($urandom);
         if (!w && k >= ds + RD_LAT && k < ds + L + RD_LAT) din = dat[k - ds - RD_LAT];
         @(negedge clk);
         exp_rv = !w && (k >= ds + RD_LAT + 1) && (k < ds + L + RD_LAT + 1);
         if (k == 0)               exp_dout = w ? CMD_WR : CMD_RD;
         else if (k == 1)          exp_dout = a[31:16];
         else if (k == 2)          exp_dout = a[15:0];
         else if (w && in_data)    exp_dout = dat[k - ds];
         else                      exp_dout = 16'h0000;
         exp = {!(k < ds + L), (k < 3) || (w && in_data), k < total,
                w && in_data && n == 1, w && in_data && n == 0,
                exp_rv && n == 1, exp_rv && n == 0, exp_dout};
         act = {ncs, oe, busy, wack[1], wack[0], rv[1], rv[0], dout};
         chk($sformatf("t%0d cyc%0d {ncs,oe,busy,wack,rv,dout}", id, k), 64'(act), 64'(exp));
         if (exp_rv) chk($sformatf("t%0d cyc%0d rdata", id, k), 64'(rdata), 64'(dat[k - ds - RD_LAT - 1]));
         if (!ncs) o_ncs++;
         if (busy) o_busy++;
         if (wack[n] || rv[n]) o_words++;
         if (rv[n] && o_first < 0) o_first = k;
      end
   endtask

   initial begin
      int r_ncs, r_busy, r_words, r_first;
      int g_who [4];
      int g_cyc [4];
      int ng;
      int n, L;
      bit w;
      logic [7:0] l;

      tbl[0] = '{0, 1'b1, 32'h0000_1000, 8'd4,   0, 16'hA001, 7,   10,  4,   -1};
      tbl[1] = '{1, 1'b0, 32'h0000_0200, 8'd2,   1, 16'h5555, 13,  16,  2,   14};
      tbl[2] = '{1, 1'b0, 32'h8000_0000, 8'd0,   2, 16'h0000, 267, 270, 256, 14};
      tbl[3] = '{0, 1'b0, 32'hDEAD_BEEE, 8'd1,   2, 16'h0000, 12,  15,  1,   14};
      tbl[4] = '{1, 1'b1, 32'h1234_5678, 8'd255, 2, 16'h0000, 258, 261, 255, -1};
      tbl[5] = '{0, 1'b1, 32'hFFFF_FFFE, 8'd1,   0, 16'h0000, 4,   7,   1,   -1};

      do_reset();
      @(negedge clk);
      chk("reset {ncs,oe,busy,rdy,wack,rv,dout}", 64'({ncs, oe, busy, rdy, wack, rv, dout}),
          64'({1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 16'h0000}));

      foreach (tbl[i]) begin
         fill(tbl[i].pat, tbl[i].base);
         run_txn(i, tbl[i].n, tbl[i].w, tbl[i].a, tbl[i].l, r_ncs, r_busy, r_words, r_first);
         chk($sformatf("t%0d ncs_low_clks", i), 64'(r_ncs), 64'(tbl[i].e_ncs));
         chk($sformatf("t%0d busy_clks", i), 64'(r_busy), 64'(tbl[i].e_busy));
         chk($sformatf("t%0d words", i), 64'(r_words), 64'(tbl[i].e_words));
         chk($sformatf("t%0d first_rvalid", i), 64'(r_first), 64'(tbl[i].e_first));
      end

      // both requesters valid in the same clk from reset: grants alternate, one per transaction slot
      do_reset();
      wr = 2'b11; len[0] = 8'd2; len[1] = 8'd2; addr[0] = 32'h100; addr[1] = 32'h200;
      v = 2'b11;
      ng = 0;
      for (int c = 0; c < 60 && ng < 4; c++) begin
         if (c > 0) tick();
         wdata[0] = 16'($urandom);
         wdata[1] = 16'($urandom);
         @(negedge clk);
         if (rdy == 2'b11) chk($sformatf("arb double grant c%0d", c), 64'(rdy), 64'd0);
         else if (rdy != 2'b00) begin
            g_who[ng] = rdy[1] ? 1 : 0;
            g_cyc[ng] = c;
            ng++;
         end
      end
      tick();
      v = 2'b00;
      chk("arb grant_count", 64'(ng), 64'd4);
      for (int i = 0; i < 4 && i < ng; i++) begin
         chk($sformatf("arb grant%0d who", i), 64'(g_who[i]), 64'(i % 2));
         chk($sformatf("arb grant%0d clk", i), 64'(g_cyc[i]), 64'(i * (1 + 3 + 2 + CS_GAP)));
      end
      for (int c = 0; c < 40 && busy; c++) tick();
      @(negedge clk);
      chk("arb drain busy", 64'(busy), 64'd0);

      // reset in the middle of write data word 2
      tick();
      v[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_4000; len[0] = 8'd4;
      @(negedge clk);
      chk("rstmid grant", 64'(rdy), 64'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         if (k == 0) v[0] = 1'b0;
         wdata[0] = 16'hB000 + 16'(k);
         if (k == 4) begin
            reset_n = 1'b0;
            v[1] = 1'b1;
         end
         @(negedge clk);
      end
      chk("rstmid word2 wack", 64'({wack, dout}), 64'({2'b01, 16'hB004}));
      chk("rstmid ready_in_reset", 64'(rdy), 64'd0);
      tick();
      @(negedge clk);
      chk("rstmid after {ncs,oe,busy,wack,dout}", 64'({ncs, oe, busy, wack, dout}),
          64'({1'b1, 1'b0, 1'b0, 2'b00, 16'h0000}));
      tick();
      reset_n = 1'b1;
      v[1] = 1'b0;
      fill(2, 16'h0);
      run_txn(10, 1, 1'b0, 32'h0000_0040, 8'd3, r_ncs, r_busy, r_words, r_first);
      chk("post_reset words", 64'(r_words), 64'd3);

      // randomized transactions against the reference walk
      for (int t = 0; t < 12; t++) begin
         n = int'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         L = ($urandom_range(0, 5) == 0) ? 256 : int'($urandom_range(1, 24));
         l = 8'(L);
         fill(2, 16'h0);
         run_txn(20 + t, n, w, $urandom, l, r_ncs, r_busy, r_words, r_first);
         chk($sformatf("r%0d ncs_low_clks", t), 64'(r_ncs), 64'(3 + (w ? 0 : DUMMY) + L));
         chk($sformatf("r%0d busy_clks", t), 64'(r_busy), 64'(3 + (w ? 0 : DUMMY) + L + CS_GAP));
         chk($sformatf("r%0d words", t), 64'(r_words), 64'(L));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
